regbank_wr_demux_8: RTL and testbench



---
 rtl/regbank_wr_demux_8.sv | 135 +++++++++++++
 tb/tb_regbank_wr_demux_8.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regbank_wr_demux_8.sv
// rtl/regbank_wr_demux_8.sv - 8 x WIDTH register bank write side with load-multiple burst sequencer (optional REG7_PC_EN)
module regbank_wr_demux_8 #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             burst_start,
    input  logic [7:0]       burst_mask,
    output logic             burst_busy,
    output logic [2:0]       burst_idx,
    output logic             burst_done,
`ifdef REG7_PC_EN
    input  logic             pc_wr,
    input  logic [WIDTH-1:0] pc_data,
`endif
    output logic [WIDTH-1:0] reg0,
    output logic [WIDTH-1:0] reg1,
    output logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] reg3,
    output logic [WIDTH-1:0] reg4,
    output logic [WIDTH-1:0] reg5,
    output logic [WIDTH-1:0] reg6,
    output logic [WIDTH-1:0] reg7
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mask_q, mask_d;
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] regs_d [8];

    logic [2:0]       first_idx;
    logic [7:0]       wr_onehot;

    // Lowest set bit of the remaining mask: the register the next beat targets.
    always_comb begin
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    // Next-state, mask bookkeeping and one-hot write decode.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        wr_onehot = 8'h00;
        case (state_q)
            IDLE: begin
                if (burst_start) begin
                    // A burst start wins over a same-cycle single write.
                    mask_d  = burst_mask;
                    state_d = (burst_mask != 8'h00) ? BURST : DONE;
                end else if (wr_valid) begin
                    wr_onehot = 8'h01 << wr_sel;
                end
            end
            BURST: begin
                if (wr_valid) begin
                    wr_onehot = 8'h01 << first_idx;
                    mask_d    = mask_q & ~(8'h01 << first_idx);
                    if ((mask_q & ~(8'h01 << first_idx)) == 8'h00) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                mask_d  = 8'h00;
            end
        endcase
    end

    // Register file next values: decoded write, then the R7 program-counter load on top.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_d[i] = wr_onehot[i] ? wr_data : regs_q[i];
        end
`ifdef REG7_PC_EN
        if (pc_wr) begin
            regs_d[7] = pc_data;
        end
`endif
    end

    // State, mask and register storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        wr_ready   = (state_q != DONE);
        burst_busy = (state_q == BURST);
        burst_done = (state_q == DONE);
        burst_idx  = (state_q == BURST) ? first_idx : 3'd0;
    end

    assign reg0 = regs_q[0];
    assign reg1 = regs_q[1];
    assign reg2 = regs_q[2];
    assign reg3 = regs_q[3];
    assign reg4 = regs_q[4];
    assign reg5 = regs_q[5];
    assign reg6 = regs_q[6];
    assign reg7 = regs_q[7];

endmodule

// File: tb/tb_regbank_wr_demux_8.sv
// tb/tb_regbank_wr_demux_8.sv - table-driven and scoreboard bench for regbank_wr_demux_8
module tb_regbank_wr_demux_8;

    logic        clk = 1'b0;
    logic        reset, wr_valid, burst_start, pc_wr;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data, pc_data;
    logic [7:0]  burst_mask;
    logic        wr_ready, burst_busy, burst_done;
    logic [2:0]  burst_idx;
    logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;

    int checks = 0;
    int failures = 0;

    regbank_wr_demux_8 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
        .burst_start(burst_start), .burst_mask(burst_mask),
        .burst_busy(burst_busy), .burst_idx(burst_idx), .burst_done(burst_done),
`ifdef REG7_PC_EN
        .pc_wr(pc_wr), .pc_data(pc_data),
`endif
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        wv;
        logic [2:0]  sel;
        logic [15:0] d;
        logic        bs;
        logic [7:0]  bm;
        logic        e_rdy;
        logic        e_busy;
        logic [2:0]  e_idx;
        logic        e_done;
    } vec_t;

    vec_t vecs[22];

    // reference model
    logic [15:0]  m_regs [8];
    int           m_state;
    logic [7:0]   m_mask;
    logic [127:0] exp_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic wv, input logic [2:0] sel,
                                input logic [15:0] d, input logic bs, input logic [7:0] bm,
                                input logic pw, input logic [15:0] pd);
        int lo;
        if (r) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            m_state = 0;
            m_mask  = 8'h00;
            return;
        end
        case (m_state)
            0: begin
                if (bs) begin
                    m_mask  = bm;
                    m_state = (bm != 0) ? 1 : 2;
                end else if (wv) begin
                    m_regs[sel] = d;
                end
            end
            1: begin
                if (wv) begin
                    lo = 0;
                    while (!m_mask[lo]) lo++;
                    m_regs[lo]   = d;
                    m_mask[lo]   = 1'b0;
                    if (m_mask == 0) m_state = 2;
                end
            end
            default: m_state = 0;
        endcase
`ifdef REG7_PC_EN
        if (pw) m_regs[7] = pd;
`endif
    endtask

    function automatic logic [127:0] pack_model();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = m_regs[i];
        return v;
    endfunction

    task automatic step(input string tag, input logic r, input logic wv, input logic [2:0] sel,
                        input logic [15:0] d, input logic bs, input logic [7:0] bm,
                        input logic pw, input logic [15:0] pd,
                        input logic e_rdy, input logic e_busy, input logic [2:0] e_idx,
                        input logic e_done);
        logic [127:0] exp_regs;
        @(negedge clk);
        reset = r; wr_valid = wv; wr_sel = sel; wr_data = d;
        burst_start = bs; burst_mask = bm; pc_wr = pw; pc_data = pd;
        #1;
        chk({tag, "_ctrl"}, 128'({wr_ready, burst_busy, burst_idx, burst_done}),
            128'({e_rdy, e_busy, e_idx, e_done}));
        model_update(r, wv, sel, d, bs, bm, pw, pd);
        exp_q.push_back(pack_model());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_regs scoreboard empty", tag);
        end else begin
            exp_regs = exp_q.pop_front();
            chk({tag, "_regs"}, {reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0}, exp_regs);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic wv, input logic [2:0] sel,
                                input logic [15:0] d, input logic bs, input logic [7:0] bm,
                                input logic e_rdy, input logic e_busy, input logic [2:0] e_idx,
                                input logic e_done);
        vec_t v;
        v.r = r; v.wv = wv; v.sel = sel; v.d = d; v.bs = bs; v.bm = bm;
        v.e_rdy = e_rdy; v.e_busy = e_busy; v.e_idx = e_idx; v.e_done = e_done;
        return v;
    endfunction

    initial begin
        logic [15:0] rd;
        //            r  wv sel  data      bs  mask      rdy busy idx done
        vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 8'h00,   1, 0, 0, 0);
        vecs[1]  = mk(0, 1, 3, 16'hBEEF, 0, 8'h00,   1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 0, 8'h00,   1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 16'h0000, 1, 8'hA5,   1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 16'h00A1, 0, 8'h00,   1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 0, 16'h00A2, 0, 8'h00,   1, 1, 2, 0);
        vecs[6]  = mk(0, 0, 0, 16'hFFFF, 1, 8'hFF,   1, 1, 5, 0);
        vecs[7]  = mk(0, 1, 0, 16'h00A3, 0, 8'h00,   1, 1, 5, 0);
        vecs[8]  = mk(0, 1, 0, 16'h00A4, 0, 8'h00,   1, 1, 7, 0);
        vecs[9]  = mk(0, 1, 0, 16'hDEAD, 1, 8'hFF,   0, 0, 0, 1);
        vecs[10] = mk(0, 0, 0, 16'h0000, 1, 8'h00,   1, 0, 0, 0);
        vecs[11] = mk(0, 1, 4, 16'h4444, 0, 8'h00,   0, 0, 0, 1);
        vecs[12] = mk(0, 1, 1, 16'h1111, 1, 8'h0F,   1, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 16'h00B0, 0, 8'h00,   1, 1, 0, 0);
        vecs[14] = mk(0, 1, 0, 16'h00B1, 0, 8'h00,   1, 1, 1, 0);
        vecs[15] = mk(1, 1, 0, 16'h00B2, 0, 8'h00,   1, 1, 2, 0);
        vecs[16] = mk(0, 0, 0, 16'h0000, 0, 8'h00,   1, 0, 0, 0);
        vecs[17] = mk(0, 1, 6, 16'h6666, 0, 8'h00,   1, 0, 0, 0);
        vecs[18] = mk(0, 1, 0, 16'hCCCC, 1, 8'h80,   1, 0, 0, 0);
        vecs[19] = mk(0, 1, 2, 16'h7777, 0, 8'h00,   1, 1, 7, 0);
        vecs[20] = mk(0, 0, 0, 16'h0000, 0, 8'h00,   0, 0, 0, 1);
        vecs[21] = mk(0, 1, 7, 16'h0707, 0, 8'h00,   1, 0, 0, 0);

        reset = 1; wr_valid = 0; wr_sel = 0; wr_data = 0;
        burst_start = 0; burst_mask = 0; pc_wr = 0; pc_data = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        m_state = 0;
        m_mask  = 8'h00;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            step($sformatf("vec%0d", i), vecs[i].r, vecs[i].wv, vecs[i].sel, vecs[i].d,
                 vecs[i].bs, vecs[i].bm, 1'b0, 16'h0000,
                 vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_idx, vecs[i].e_done);
        end

        // full-mask burst: eight beats in ascending order
        step("ff_start", 0, 0, 0, 16'h0000, 1, 8'hFF, 0, 16'h0000, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            rd = 16'($urandom);
            step($sformatf("ff_beat%0d", i), 0, 1, 3'(7 - i), rd, 0, 8'h00, 0, 16'h0000,
                 1, 1, 3'(i), 0);
        end
        step("ff_done", 0, 1, 0, 16'h1234, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 1);
        step("ff_idle", 0, 0, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 0);

        // single-bit mask: one beat, with a long stall first
        step("one_start", 0, 0, 0, 16'h0000, 1, 8'h10, 0, 16'h0000, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("one_stall%0d", i), 0, 0, 0, 16'h0000, 1, 8'h01, 0, 16'h0000,
                 1, 1, 4, 0);
        step("one_beat", 0, 1, 0, 16'h4A4A, 0, 8'h00, 0, 16'h0000, 1, 1, 4, 0);
        step("one_done", 0, 0, 0, 16'h0000, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 1);

`ifdef REG7_PC_EN
        // pc load overrides a burst beat to R7; beat still consumed
        step("pc_start", 0, 0, 0, 16'h0000, 1, 8'h81, 0, 16'h0000, 1, 0, 0, 0);
        step("pc_beat0", 0, 1, 0, 16'h1010, 0, 8'h00, 0, 16'h0000, 1, 1, 0, 0);
        step("pc_beat7", 0, 1, 0, 16'h5555, 0, 8'h00, 1, 16'h0042, 1, 1, 7, 0);
        step("pc_done", 0, 0, 0, 16'h0000, 0, 8'h00, 1, 16'h0099, 0, 0, 0, 1);
        step("pc_idle", 0, 1, 7, 16'hAAAA, 0, 8'h00, 1, 16'h0100, 1, 0, 0, 0);
        step("pc_rst", 1, 0, 0, 16'h0000, 0, 8'h00, 1, 16'hFFFF, 1, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
